disp_scan: RTL and testbench
============================

DISP_SCAN -- requirements
Module: disp_scan

Interface
REQ-001 Parameter SCAN_DIV, default 2, clk_1Khz cycles per digit slot (legal range 1..255).
REQ-002 Parameter ACTIVE_LOW, default 1; 1 = seg, dp and an drive low to light, 0 = drive high to light.
REQ-003 clk_1Khz  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 dispbuf  input  24  six BCD digits from the stopwatch counter: [23:20] minute1, [19:16] minute0, [15:12] sec1, [11:8] sec0, [7:4] msec2, [3:0] msec1.
REQ-006 disp_en  input  1  1 = scan and drive the display; 0 = all digits dark.
REQ-007 blank_lz  input  1  1 = enable leading-zero blanking.
REQ-008 seg  output  7  segment drive, bit0 = a through bit6 = g, registered.
REQ-009 dp  output  1  decimal-point drive, registered.
REQ-010 an  output  6  digit-enable drive, one-hot when active, bit k = digit k, registered.
REQ-011 frame_done  output  1  one-cycle pulse at each frame start, registered.

Function
REQ-012 Digit k maps to snapshot nibble [4k+3:4k]; digit 0 is the rightmost digit (msec1) and digit 5 is the leftmost (minute1).
REQ-013 The prescaler counts 0..SCAN_DIV-1 while disp_en=1; a tick occurs in the cycle it equals SCAN_DIV-1, after which it wraps to 0.
REQ-014 On a tick, the digit index advances idx+1; from idx=5 it wraps to 0, and that wrap is a frame start.
REQ-015 A frame start also occurs on the first enabled cycle after reset release and on the first cycle after disp_en rises; it forces idx=0 and prescaler=0.
REQ-016 At every frame start, snapshot <= dispbuf and frame_done=1 in the following cycle; dispbuf changes mid-frame are never displayed until the next frame start.
REQ-017 Outputs are registered: seg, dp and an reflect the idx and snapshot values of the previous cycle, so latency is 1 cycle.
REQ-018 Exactly one an bit is active while disp_en=1; each digit is active for SCAN_DIV consecutive cycles; a frame is 6*SCAN_DIV cycles.
REQ-019 Active-high segment codes: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
REQ-020 A nibble value from 10 to 15 displays a dash (0x40); such a digit is never blanked.
REQ-021 dp is active only while digit 2 (sec0) is active; this marks the seconds/milliseconds split.
REQ-022 When blank_lz=1, digit 5 is blanked if it is 0.
REQ-023 When blank_lz=1, digit 4 is blanked if it is 0 and digit 5 is blanked.
REQ-024 When blank_lz=1, digit 3 is blanked if it is 0 and digit 4 is blanked.
REQ-025 Digits 2..0 are never blanked.
REQ-026 Blanking is evaluated on the snapshot.
REQ-027 A blanked digit keeps its an bit active with all segments dark, so scan timing does not change.
REQ-028 When disp_en=0: an, seg and dp are inactive from the next cycle, the prescaler and idx hold at 0, and frame_done=0.
REQ-029 Inactive/dark level is all-1 when ACTIVE_LOW=1 and all-0 when ACTIVE_LOW=0; ACTIVE_LOW also inverts the active levels of REQ-019..REQ-021.

Reset
REQ-030 While rst=0: prescaler=0, idx=0, snapshot=0, frame_done=0, and an, seg and dp are at their inactive level, asynchronously.
REQ-031 Reset asserted mid-frame aborts the frame immediately; after release, REQ-015 applies.

Verification
REQ-032 SCAN_DIV=2, ACTIVE_LOW=0, disp_en=1, blank_lz=1, dispbuf=24'h012345, release rst -> frame_done pulses once. Then an steps 000001 → 000010 → ... → 100000 every 2 cycles with seg 0x6D, 0x66, 0x4F(dp=1), 0x5B, 0x06, 0x00.
REQ-033 Same setup, dispbuf changed to 24'h999999 mid-frame -> the current frame still shows 012345. The next frame shows 0x6F on all six digits and frame_done pulses every 12 cycles.
REQ-034 ACTIVE_LOW=0, blank_lz=1, dispbuf=24'h000007 -> digits 5, 4 and 3 show seg=0x00. Digit 2 shows 0x3F with dp=1; digits 1 and 0 show 0x3F and 0x07. With blank_lz=0, digits 5..3 show 0x3F.
REQ-035 ACTIVE_LOW=0, dispbuf=24'hA00000, blank_lz=1 -> digit 5 shows 0x40 and digit 4 shows 0x3F (not blanked).
REQ-036 Mid-frame disp_en=0 for 5 cycles, then 1 -> the next cycle an=000000. After re-enable, frame_done pulses, a fresh snapshot is taken and the scan restarts at digit 0.
REQ-037 ACTIVE_LOW=1, rst pulsed low mid-digit -> an=6'h3F, seg=7'h7F, dp=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/disp_scan.sv
// Six-digit multiplexed 7-segment scanner for the stopwatch display.
// Takes a dispbuf snapshot at each frame start and applies leading-zero blanking to digits 5..3.
module disp_scan #(
   parameter int unsigned SCAN_DIV   = 2,
   parameter bit          ACTIVE_LOW = 1'b1
) (
   input  logic        clk_1Khz,
   input  logic        rst,
   input  logic [23:0] dispbuf,
   input  logic        disp_en,
   input  logic        blank_lz,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [5:0]  an,
   output logic        frame_done
);

   localparam logic [7:0] PRE_MAX = 8'(SCAN_DIV - 1);
   localparam logic [6:0] SEG_INV = {7{ACTIVE_LOW}};
   localparam logic [5:0] AN_INV  = {6{ACTIVE_LOW}};

   logic [7:0]  r_pre;
   logic [2:0]  r_idx;
   logic [23:0] r_snap;
   logic        r_run;
   logic [6:0]  r_seg;
   logic        r_dp;
   logic [5:0]  r_an;
   logic        r_fd;

   logic [7:0]  w_pre_d;
   logic [2:0]  w_idx_d;
   logic        w_tick;
   logic        w_fs;
   logic        w_show;
   logic [3:0]  w_nib;
   logic        w_blank;
   logic        w_b5;
   logic        w_b4;
   logic        w_b3;
   logic [6:0]  w_seg_on;
   logic [6:0]  w_seg_d;
   logic [5:0]  w_an_d;
   logic        w_dp_d;

   function automatic logic [6:0] seg_code(input logic [3:0] nib);
      logic [6:0] code;
      unique case (nib)
         4'd0:    code = 7'h3F;
         4'd1:    code = 7'h06;
         4'd2:    code = 7'h5B;
         4'd3:    code = 7'h4F;
         4'd4:    code = 7'h66;
         4'd5:    code = 7'h6D;
         4'd6:    code = 7'h7D;
         4'd7:    code = 7'h07;
         4'd8:    code = 7'h7F;
         4'd9:    code = 7'h6F;
         default: code = 7'h40;
      endcase
      return code;
   endfunction

   always_comb begin
      w_tick  = (r_pre == PRE_MAX);
      // r_run low means this is the first enabled cycle since reset or since disp_en rose
      w_fs    = disp_en && (!r_run || (w_tick && (r_idx == 3'd5)));
      w_pre_d = r_pre + 8'd1;
      w_idx_d = r_idx;
      if (!disp_en || w_fs || w_tick) begin
         w_pre_d = 8'd0;
      end
      if (!disp_en || w_fs) begin
         w_idx_d = 3'd0;
      end else if (w_tick) begin
         w_idx_d = r_idx + 3'd1;
      end
   end

   always_comb begin
      w_b5 = blank_lz && (r_snap[23:20] == 4'd0);
      w_b4 = w_b5 && (r_snap[19:16] == 4'd0);
      w_b3 = w_b4 && (r_snap[15:12] == 4'd0);
      w_nib   = 4'd0;
      w_blank = 1'b0;
      unique case (r_idx)
         3'd0:    w_nib = r_snap[3:0];
         3'd1:    w_nib = r_snap[7:4];
         3'd2:    w_nib = r_snap[11:8];
         3'd3:    begin w_nib = r_snap[15:12]; w_blank = w_b3; end
         3'd4:    begin w_nib = r_snap[19:16]; w_blank = w_b4; end
         3'd5:    begin w_nib = r_snap[23:20]; w_blank = w_b5; end
         default: w_nib = 4'd0;
      endcase
      w_show   = disp_en && r_run;
      w_seg_on = w_blank ? 7'h00 : seg_code(w_nib);
      w_seg_d  = SEG_INV;
      w_an_d   = AN_INV;
      w_dp_d   = ACTIVE_LOW;
      if (w_show) begin
         w_seg_d = w_seg_on ^ SEG_INV;
         w_an_d  = (6'b1 << r_idx) ^ AN_INV;
         w_dp_d  = (r_idx == 3'd2) ^ ACTIVE_LOW;
      end
   end

   always_ff @(posedge clk_1Khz or negedge rst) begin
      if (!rst) begin
         r_pre  <= 8'd0;
         r_idx  <= 3'd0;
         r_snap <= 24'd0;
         r_run  <= 1'b0;
         r_seg  <= SEG_INV;
         r_dp   <= ACTIVE_LOW;
         r_an   <= AN_INV;
         r_fd   <= 1'b0;
      end else begin
         r_pre <= w_pre_d;
         r_idx <= w_idx_d;
         r_run <= disp_en;
         if (w_fs) begin
            r_snap <= dispbuf;
         end
         r_seg <= w_seg_d;
         r_dp  <= w_dp_d;
         r_an  <= w_an_d;
         r_fd  <= w_fs;
      end
   end

   assign seg        = r_seg;
   assign dp         = r_dp;
   assign an         = r_an;
   assign frame_done = r_fd;

endmodule

// File: tb/tb_disp_scan.sv
// Scoreboard bench for disp_scan: two instances (SCAN_DIV=2 active-high, SCAN_DIV=3 active-low)
// share stimulus; a frame-position model predicts every cycle's outputs.
module tb_disp_scan;

   logic        clk_1Khz = 1'b0;
   logic        rst      = 1'b1;
   logic        disp_en  = 1'b0;
   logic        blank_lz = 1'b0;
   logic [23:0] dispbuf  = 24'd0;

   logic [6:0] seg0, seg1;
   logic       dp0, dp1;
   logic [5:0] an0, an1;
   logic       fd0, fd1;

   int n_vec = 0;
   int n_err = 0;

   logic [14:0] q0[$];
   logic [14:0] q1[$];

   int          dv[2]   = '{2, 3};
   bit          alv[2]  = '{1'b0, 1'b1};
   int          pos[2]  = '{0, 0};
   logic [23:0] snap[2] = '{24'd0, 24'd0};
   logic        prev[2] = '{1'b0, 1'b0};
   int          seg_tab[10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

   disp_scan #(.SCAN_DIV(2), .ACTIVE_LOW(1'b0)) u_dut0 (
      .clk_1Khz(clk_1Khz), .rst(rst), .dispbuf(dispbuf), .disp_en(disp_en),
      .blank_lz(blank_lz), .seg(seg0), .dp(dp0), .an(an0), .frame_done(fd0)
   );

   disp_scan #(.SCAN_DIV(3), .ACTIVE_LOW(1'b1)) u_dut1 (
      .clk_1Khz(clk_1Khz), .rst(rst), .dispbuf(dispbuf), .disp_en(disp_en),
      .blank_lz(blank_lz), .seg(seg1), .dp(dp1), .an(an1), .frame_done(fd1)
   );

   always #5 clk_1Khz = ~clk_1Khz;

   // Packed expectation {an, seg, dp, frame_done} for one displayed digit.
   function automatic logic [14:0] exp_out(input int i, input logic [23:0] s, input logic z,
                                           input logic show, input int digit, input logic fs);
      logic [3:0] nib;
      logic       blank;
      logic [6:0] sg;
      logic [5:0] a;
      logic       d;
      nib   = 4'(s >> (4 * digit));
      // leading zero: this digit and every digit to its left are zero
      blank = z && (digit >= 3) && ((s >> (4 * digit)) == 24'd0);
      sg    = (nib > 4'd9) ? 7'h40 : 7'(seg_tab[nib]);
      if (blank) sg = 7'h00;
      a = 6'(1 << digit);
      d = (digit == 2);
      if (!show) begin
         a  = 6'h00;
         sg = 7'h00;
         d  = 1'b0;
      end
      if (alv[i]) begin
         a  = ~a;
         sg = ~sg;
         d  = ~d;
      end
      return {a, sg, d, fs};
   endfunction

   task automatic chk(input string nm, input logic [14:0] act, input logic [14:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s t=%0t: got an=%h seg=%h dp=%b fd=%b, expected an=%h seg=%h dp=%b fd=%b",
                  nm, $time, act[14:9], act[8:2], act[1], act[0],
                  exp[14:9], exp[8:2], exp[1], exp[0]);
      end
   endtask

   task automatic model_step();
      logic [14:0] e;
      logic        fs;
      for (int i = 0; i < 2; i++) begin
         if (!rst) begin
            e       = exp_out(i, 24'd0, 1'b0, 1'b0, 0, 1'b0);
            pos[i]  = 0;
            snap[i] = 24'd0;
            prev[i] = 1'b0;
         end else begin
            fs = disp_en && (!prev[i] || (pos[i] == 6 * dv[i] - 1));
            e  = exp_out(i, snap[i], blank_lz, disp_en && prev[i], pos[i] / dv[i], fs);
            if (fs) begin
               snap[i] = dispbuf;
               pos[i]  = 0;
            end else if (disp_en) begin
               pos[i] = pos[i] + 1;
            end else begin
               pos[i] = 0;
            end
            prev[i] = disp_en;
         end
         if (i == 0) q0.push_back(e);
         else        q1.push_back(e);
      end
   endtask

   // Predictor: pushes the expected post-edge outputs for every clock.
   initial forever begin
      @(posedge clk_1Khz);
      model_step();
   end

   // Monitor: outputs are registered, so compare 1 time unit after each edge.
   initial forever begin
      @(posedge clk_1Khz);
      #1;
      if (q0.size() > 0) chk("d0_out", {an0, seg0, dp0, fd0}, q0.pop_front());
      if (q1.size() > 0) chk("d1_out", {an1, seg1, dp1, fd1}, q1.pop_front());
   end

   task automatic run(input logic e, input logic [23:0] b, input logic z, input int n);
      @(negedge clk_1Khz);
      disp_en  = e;
      dispbuf  = b;
      blank_lz = z;
      repeat (n - 1) @(negedge clk_1Khz);
   endtask

   function automatic logic [23:0] rand_buf();
      logic [23:0] b;
      for (int k = 0; k < 6; k++) begin
         b[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      end
      return b;
   endfunction

   initial begin
      #1 rst = 1'b0;
      repeat (3) @(negedge clk_1Khz);
      rst = 1'b1;
      run(1'b1, 24'h012345, 1'b1, 30);
      run(1'b1, 24'h999999, 1'b1, 40);
      run(1'b1, 24'h000007, 1'b1, 40);
      run(1'b1, 24'h000007, 1'b0, 40);
      run(1'b1, 24'hA00000, 1'b1, 40);
      run(1'b1, 24'h0000FF, 1'b1, 7);
      run(1'b0, 24'h0000FF, 1'b1, 5);
      run(1'b1, 24'h123456, 1'b1, 30);

      // Asynchronous reset mid-digit: outputs must go inactive before any clock edge.
      @(negedge clk_1Khz);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_d0", {an0, seg0, dp0, fd0}, {6'h00, 7'h00, 1'b0, 1'b0});
      chk("async_rst_d1", {an1, seg1, dp1, fd1}, {6'h3F, 7'h7F, 1'b1, 1'b0});
      @(negedge clk_1Khz);
      rst = 1'b1;
      run(1'b1, 24'h000300, 1'b1, 30);

      for (int c = 0; c < 3000; c++) begin
         @(negedge clk_1Khz);
         if (disp_en) begin
            if ($urandom_range(0, 59) == 0) disp_en = 1'b0;
         end else if ($urandom_range(0, 3) == 0) begin
            disp_en = 1'b1;
         end
         if ($urandom_range(0, 7) == 0)   dispbuf  = rand_buf();
         if ($urandom_range(0, 31) == 0)  blank_lz = ~blank_lz;
         rst = ($urandom_range(0, 299) != 0);
      end

      @(negedge clk_1Khz);
      rst = 1'b1;
      repeat (3) @(negedge clk_1Khz);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
